// File: rtl/mem_resp_t_pkg.sv
// Shared CPU package: byte width, request address width and the state
// encoding of the 3-byte memory responder.
package mem_resp_t_pkg;

  localparam int BYTE          = 8;
  localparam int MEM_ADDR_SIZE = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RESP = 3'd4,
    WACK = 3'd5
  } mem_resp_state_t;

endpackage : mem_resp_t_pkg

// File: rtl/mem_resp_t_byte_ram.sv
// byte_ram_t: single-port byte-wide store, synchronous write and
// combinational read. Contents are never cleared.
module byte_ram_t
  import mem_resp_t_pkg::*;
#(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [BYTE-1:0]       wdata_i,
  output logic [BYTE-1:0]       rdata_o
);

  logic [BYTE-1:0] mem_q [2**DEPTH_LOG2];

  // Write port: one byte per enabled clock edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule : byte_ram_t

// File: rtl/mem_resp_t.sv
// mem_resp_t: accepts a byte write or a 3-byte little-endian read, walks
// the bytes one per cycle and signals completion with a one-cycle valid_o.
// Optional macro MEM_RESP_MIRROR_EN: addresses alias modulo the store size;
// without it, bytes above the store read as zero and writes there are lost.
module mem_resp_t
  import mem_resp_t_pkg::BYTE;
  import mem_resp_t_pkg::mem_resp_state_t;
  import mem_resp_t_pkg::IDLE;
  import mem_resp_t_pkg::RD0;
  import mem_resp_t_pkg::RD1;
  import mem_resp_t_pkg::RD2;
  import mem_resp_t_pkg::RESP;
  import mem_resp_t_pkg::WACK;
#(
  parameter int MEM_ADDR_SIZE = mem_resp_t_pkg::MEM_ADDR_SIZE,
  parameter int DEPTH_LOG2    = 11
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [MEM_ADDR_SIZE-1:0] addr_i,
  input  logic [BYTE-1:0]          wdata_i,
  output logic [3*BYTE-1:0]        data_o,
  output logic                     valid_o,
  output logic                     busy_o
);

  mem_resp_state_t state_q, state_d;
  logic [MEM_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [2*BYTE-1:0]        lane_q, lane_d;
  logic [3*BYTE-1:0]        data_q, data_d;

  logic [MEM_ADDR_SIZE-1:0] cur_addr;
  logic [DEPTH_LOG2-1:0]    ram_addr;
  logic                     in_range;
  logic                     ram_we;
  logic [BYTE-1:0]          ram_rdata;
  logic [BYTE-1:0]          rd_byte;

  // In IDLE the RAM port serves the incoming write; otherwise it follows
  // the byte pointer of the read in progress.
  assign cur_addr = (state_q == IDLE) ? addr_i : addr_q;
  assign ram_addr = cur_addr[DEPTH_LOG2-1:0];

`ifdef MEM_RESP_MIRROR_EN
  // Upper address bits are ignored, so every address lands in the store.
  assign in_range = 1'b1;
`else
  assign in_range = ~(|cur_addr[MEM_ADDR_SIZE-1:DEPTH_LOG2]);
`endif

  assign rd_byte = in_range ? ram_rdata : '0;

  // Writes commit on the edge closing the accept cycle, never under reset.
  assign ram_we = rstn_i && (state_q == IDLE) && req_i && we_i && in_range;

  byte_ram_t #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(wdata_i),
    .rdata_o(ram_rdata)
  );

  // Next-state and outputs: collect lanes 0/1, publish all three at RD2.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    data_d  = data_q;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          state_d = we_i ? WACK : RD0;
        end
      end
      RD0: begin
        lane_d[BYTE-1:0] = rd_byte;
        addr_d           = addr_q + 1'b1;
        state_d          = RD1;
      end
      RD1: begin
        lane_d[2*BYTE-1:BYTE] = rd_byte;
        addr_d                = addr_q + 1'b1;
        state_d               = RD2;
      end
      RD2: begin
        data_d  = {rd_byte, lane_q};
        state_d = RESP;
      end
      RESP: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      WACK: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = (state_q != IDLE);

endmodule : mem_resp_t

// File: doc/mem_resp_t.md
MEM_RESP_T -- requirements
Module: mem_resp_t

Interface
REQ-001 Parameter MEM_ADDR_SIZE, default 16, SHALL set the request address width.
REQ-002 Parameter DEPTH_LOG2, default 11, SHALL set the backing store to 2**DEPTH_LOG2 bytes (2 KiB).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rstn_i  input  1  SHALL be a synchronous, active-low reset.
REQ-005 req_i  input  1  SHALL request a transaction; sampled only in IDLE.
REQ-006 we_i  input  1  SHALL select a write (1) or a 3-byte read (0) for the accepted request.
REQ-007 addr_i  input  MEM_ADDR_SIZE  SHALL give the byte address of the request.
REQ-008 wdata_i  input  8  SHALL give the write byte.
REQ-009 data_o  output  24  SHALL return read data: [7:0]=mem[a], [15:8]=mem[a+1], [23:16]=mem[a+2].
REQ-010 valid_o  output  1  SHALL pulse high for one cycle to signal completion; it is the CPU's mem_valid input.
REQ-011 busy_o  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL use states IDLE, RD0, RD1, RD2, RESP and WACK.
REQ-013 In IDLE with req_i=1, the block SHALL accept the request: latch addr_i, then go to RD0 (we_i=0) or WACK (we_i=1).
REQ-014 req_i outside IDLE SHALL be ignored, with no queuing.
REQ-015 RD0, RD1 and RD2 SHALL each read one byte (a, a+1, a+2) into byte lanes 0, 1 and 2, one byte per cycle, then advance.
REQ-016 Byte address increments SHALL wrap modulo 2**MEM_ADDR_SIZE (0xFFFF+1 -> 0x0000).
REQ-017 RD2 SHALL go to RESP; RESP SHALL drive valid_o=1 for exactly one cycle, then go to IDLE.
REQ-018 Read latency SHALL be fixed: accept in cycle N gives valid_o in cycle N+4, and the next accept is possible in N+5.
REQ-019 A write SHALL update the byte at the edge ending the accept cycle N; WACK (cycle N+1) SHALL drive valid_o=1 and then return to IDLE.
REQ-020 data_o SHALL hold its last read value until the RESP cycle of the next read; writes SHALL NOT change data_o.
REQ-021 A read accepted after a write completes SHALL return the newly written byte.
REQ-022 valid_o SHALL be 0 in IDLE, RD0, RD1 and RD2.

Reset
REQ-023 With rstn_i=0 at a rising edge, the state SHALL become IDLE, data_o=24'h000000, valid_o=0 and busy_o=0.
REQ-024 Reset during any read or write state SHALL abort the transaction with no valid_o pulse.
REQ-025 Storage contents SHALL NOT be cleared by reset.
REQ-026 A write accepted in the same cycle that rstn_i=0 SHALL NOT update storage.

Configuration
REQ-027 With macro MEM_RESP_MIRROR_EN defined, addresses SHALL alias modulo 2**DEPTH_LOG2 (NES RAM mirroring: 0x0800 aliases 0x0000).
REQ-028 Without MEM_RESP_MIRROR_EN, bytes at addresses >= 2**DEPTH_LOG2 SHALL read as 8'h00 and writes to them SHALL be dropped; valid_o timing SHALL be unchanged.

Structure
REQ-029 The state enum mem_resp_state_t and the BYTE and MEM_ADDR_SIZE constants SHALL live in the shared CPU package.
REQ-030 Storage SHALL be a sub-module byte_ram_t: single-port, 8-bit wide, synchronous write, combinational read.
REQ-031 Address translation (mirror or out-of-range) and the FSM SHALL reside in mem_resp_t.

Verification
REQ-032 Scenario: reset, then read at 0x0000 -> valid_o in cycle N+4 and data_o=24'h000000 or the preload; busy_o high in N+1 to N+4.
REQ-033 Scenario: write 0xA9 to 0x0010, 0x05 to 0x0011, 0x8D to 0x0012, then read at 0x0010 -> data_o=24'h8D05A9; each write gives valid_o in N+1.
REQ-034 Scenario: req_i held high during RD1 with a different address -> ignored; data_o reflects only the first address.
REQ-035 Scenario: rstn_i=0 in RD1 -> no valid_o pulse, data_o=0, state IDLE; a following read returns the stored bytes unchanged.
REQ-036 Scenario (MIRROR_EN): write 0x42 to 0x0000, then read at 0x0800 -> data_o[7:0]=0x42; without the macro, data_o[7:0]=0x00.
REQ-037 Scenario: read at 0xFFFF with mirroring -> lanes come from 0x07FF, 0x0000 and 0x0001 (wrap, then alias).
